// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC point sequencer: GF opcodes, FSM states,
// register-file indices, microprogram lengths and the microcode entry layout.
// No logic of its own; latency and backpressure do not apply.
package ecc_pkg;

   // Opcodes as seen by the GF unit's operation select
   localparam int          OP_W   = 2;
   localparam logic [1:0]  GF_ADD = 2'd0;
   localparam logic [1:0]  GF_SUB = 2'd1;
   localparam logic [1:0]  GF_MUL = 2'd2;
   localparam logic [1:0]  GF_DIV = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Register file: inputs in r0..r4, temporaries in r5..r7.
   // r6/r7 end up holding x3/y3.
   localparam int               REG_W = 3;
   localparam logic [REG_W-1:0] R_X1  = 3'd0;
   localparam logic [REG_W-1:0] R_Y1  = 3'd1;
   localparam logic [REG_W-1:0] R_X2  = 3'd2;
   localparam logic [REG_W-1:0] R_Y2  = 3'd3;
   localparam logic [REG_W-1:0] R_A   = 3'd4;
   localparam logic [REG_W-1:0] R_T5  = 3'd5;
   localparam logic [REG_W-1:0] R_T6  = 3'd6;
   localparam logic [REG_W-1:0] R_T7  = 3'd7;

   localparam int PC_W    = 4;
   localparam int ADD_LEN = 9;
   localparam int DBL_LEN = 12;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] dst;
      logic [REG_W-1:0] src_a;
      logic [REG_W-1:0] src_b;
      logic             last;
   } rom_entry_t;

   function automatic rom_entry_t mk_entry(input logic [OP_W-1:0]  op,
                                           input logic [REG_W-1:0] dst,
                                           input logic [REG_W-1:0] src_a,
                                           input logic [REG_W-1:0] src_b);
      rom_entry_t e;
      e.op    = op;
      e.dst   = dst;
      e.src_a = src_a;
      e.src_b = src_b;
      e.last  = 1'b0;
      return e;
   endfunction

endpackage

// File: rtl/ecc_ucode_rom.sv
// Microcode ROM for affine point add / double: (mode, pc) -> one GF operation.
// Purely combinational, zero latency; no flow control.
// Ports: i_mode (0 add, 1 double), i_pc; o_op, o_dst, o_src_a, o_src_b, o_last.
module ecc_ucode_rom
   import ecc_pkg::*;
(
   input  logic              i_mode,
   input  logic [PC_W-1:0]   i_pc,
   output logic [OP_W-1:0]   o_op,
   output logic [REG_W-1:0]  o_dst,
   output logic [REG_W-1:0]  o_src_a,
   output logic [REG_W-1:0]  o_src_b,
   output logic              o_last
);

   rom_entry_t e;

   always_comb begin
      e = mk_entry(GF_ADD, R_T5, R_X1, R_X1);
      if (!i_mode) begin
         // lambda = (y2-y1)/(x2-x1); x3 = l^2-x1-x2; y3 = l*(x1-x3)-y1
         case (i_pc)
            4'd0: e = mk_entry(GF_SUB, R_T5, R_Y2, R_Y1);
            4'd1: e = mk_entry(GF_SUB, R_T6, R_X2, R_X1);
            4'd2: e = mk_entry(GF_DIV, R_T5, R_T5, R_T6);
            4'd3: e = mk_entry(GF_MUL, R_T6, R_T5, R_T5);
            4'd4: e = mk_entry(GF_SUB, R_T6, R_T6, R_X1);
            4'd5: e = mk_entry(GF_SUB, R_T6, R_T6, R_X2);
            4'd6: e = mk_entry(GF_SUB, R_T7, R_X1, R_T6);
            4'd7: e = mk_entry(GF_MUL, R_T7, R_T5, R_T7);
            4'd8: e = mk_entry(GF_SUB, R_T7, R_T7, R_Y1);
            default: ;
         endcase
         e.last = (i_pc >= PC_W'(ADD_LEN - 1));
      end else begin
         // lambda = (3*x1^2 + a)/(2*y1); x3 = l^2-2*x1; y3 = l*(x1-x3)-y1
         case (i_pc)
            4'd0:  e = mk_entry(GF_MUL, R_T5, R_X1, R_X1);
            4'd1:  e = mk_entry(GF_ADD, R_T6, R_T5, R_T5);
            4'd2:  e = mk_entry(GF_ADD, R_T5, R_T6, R_T5);
            4'd3:  e = mk_entry(GF_ADD, R_T5, R_T5, R_A);
            4'd4:  e = mk_entry(GF_ADD, R_T6, R_Y1, R_Y1);
            4'd5:  e = mk_entry(GF_DIV, R_T5, R_T5, R_T6);
            4'd6:  e = mk_entry(GF_MUL, R_T6, R_T5, R_T5);
            4'd7:  e = mk_entry(GF_SUB, R_T6, R_T6, R_X1);
            4'd8:  e = mk_entry(GF_SUB, R_T6, R_T6, R_X1);
            4'd9:  e = mk_entry(GF_SUB, R_T7, R_X1, R_T6);
            4'd10: e = mk_entry(GF_MUL, R_T7, R_T5, R_T7);
            4'd11: e = mk_entry(GF_SUB, R_T7, R_T7, R_Y1);
            default: ;
         endcase
         e.last = (i_pc >= PC_W'(DBL_LEN - 1));
      end
   end

   assign o_op    = e.op;
   assign o_dst   = e.dst;
   assign o_src_a = e.src_a;
   assign o_src_b = e.src_b;
   assign o_last  = e.last;

endmodule

// File: rtl/ecc_point_ctrl.sv
// Affine EC point add / double sequencer driving one shared GF arithmetic unit.
// Latency: 1 entry cycle + per op (ISSUE + WAIT >= 1 + unit latency) + 1 DONE cycle.
// Backpressure: i_start ignored while busy; WAIT stalls on gf_done
// (bounded by TIMEOUT_CYCLES when ECC_POINT_CTRL_TIMEOUT_EN is defined).
// Ports: i_start/i_mode/i_x1..i_y2/i_a request; o_busy/o_done/o_err/o_x3/o_y3
// result; gf_op/gf_in_0/gf_in_1/gf_start issue and gf_done/gf_result return.
module ecc_point_ctrl
   import ecc_pkg::*;
#(
   parameter int SIZE           = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_mode,
   input  logic [SIZE-1:0] i_x1,
   input  logic [SIZE-1:0] i_y1,
   input  logic [SIZE-1:0] i_x2,
   input  logic [SIZE-1:0] i_y2,
   input  logic [SIZE-1:0] i_a,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_err,
   output logic [SIZE-1:0] o_x3,
   output logic [SIZE-1:0] o_y3,
   output logic [1:0]      gf_op,
   output logic [SIZE-1:0] gf_in_0,
   output logic [SIZE-1:0] gf_in_1,
   output logic            gf_start,
   input  logic            gf_done,
   input  logic [SIZE-1:0] gf_result
);

   state_t             state, state_nxt;
   logic [PC_W-1:0]    pc, pc_nxt;
   logic               mode_q, mode_nxt;
   logic               err_nxt;
   logic [SIZE-1:0]    rf     [8];
   logic [SIZE-1:0]    rf_nxt [8];
   logic [REG_W-1:0]   dst_q;
   logic               last_q;
   logic               div0_q;

   logic [OP_W-1:0]    rom_op;
   logic [REG_W-1:0]   rom_dst, rom_src_a, rom_src_b;
   logic               rom_last;
   logic               rom_div0;

   // The ROM is addressed with the *next* pc/mode so the issue registers can
   // be loaded on the edge entering ISSUE, with rf_nxt forwarding the result
   // being written on that same edge.
   ecc_ucode_rom u_rom (
      .i_mode  (mode_nxt),
      .i_pc    (pc_nxt),
      .o_op    (rom_op),
      .o_dst   (rom_dst),
      .o_src_a (rom_src_a),
      .o_src_b (rom_src_b),
      .o_last  (rom_last)
   );

   assign rom_div0 = (rom_op == GF_DIV) && (rf_nxt[rom_src_b] == '0);

`ifdef ECC_POINT_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt <= '0;
      end else if (state == S_ISSUE) begin
         tmo_cnt <= '0;
      end else if (state == S_WAIT) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end
`else
   // The timeout bound has no effect when the watchdog is compiled out.
   if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
   end
`endif

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      mode_nxt  = mode_q;
      err_nxt   = 1'b0;
      rf_nxt    = rf;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               rf_nxt[R_X1] = i_x1;
               rf_nxt[R_Y1] = i_y1;
               rf_nxt[R_X2] = i_x2;
               rf_nxt[R_Y2] = i_y2;
               rf_nxt[R_A]  = i_a;
               mode_nxt     = i_mode;
               pc_nxt       = '0;
               state_nxt    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // gf_done is deliberately not looked at here.
            if (div0_q) begin
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (gf_done) begin
               rf_nxt[dst_q] = gf_result;
               if (last_q) begin
                  state_nxt = S_DONE;
               end else begin
                  pc_nxt    = pc + PC_W'(1);
                  state_nxt = S_ISSUE;
               end
            end
`ifdef ECC_POINT_CTRL_TIMEOUT_EN
            else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end
`endif
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         pc       <= '0;
         mode_q   <= 1'b0;
         for (int i = 0; i < 8; i++) rf[i] <= '0;
         dst_q    <= '0;
         last_q   <= 1'b0;
         div0_q   <= 1'b0;
         gf_op    <= '0;
         gf_in_0  <= '0;
         gf_in_1  <= '0;
         gf_start <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_err    <= 1'b0;
         o_x3     <= '0;
         o_y3     <= '0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         mode_q <= mode_nxt;
         rf     <= rf_nxt;
         o_busy <= (state_nxt != S_IDLE);
         o_done <= (state_nxt == S_DONE);

         if (state_nxt == S_ISSUE) begin
            gf_op    <= rom_op;
            gf_in_0  <= rf_nxt[rom_src_a];
            gf_in_1  <= rf_nxt[rom_src_b];
            dst_q    <= rom_dst;
            last_q   <= rom_last;
            div0_q   <= rom_div0;
            // A zero divisor means the point at infinity: never issue it.
            gf_start <= !rom_div0;
         end else begin
            gf_start <= 1'b0;
         end

         if (state_nxt == S_DONE) begin
            o_err <= err_nxt;
            // On abort the previous result stays visible.
            if (!err_nxt) begin
               o_x3 <= rf_nxt[R_T6];
               o_y3 <= rf_nxt[R_T7];
            end
         end
      end
   end

endmodule

// File: tb/tb_ecc_point_ctrl.sv
// Self-checking bench for ecc_point_ctrl over p=23, a=1 with a behavioural
// GF unit of random latency. Expected results are queued by the stimulus and
// checked by a monitor whenever o_done pulses.
module tb_ecc_point_ctrl;

   localparam int SIZE = 32;
   localparam int P    = 23;
`ifdef ECC_POINT_CTRL_TIMEOUT_EN
   localparam int MAX_LAT = 12;
`else
   localparam int MAX_LAT = 40;
`endif

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b0;
   logic            i_start = 1'b0;
   logic            i_mode = 1'b0;
   logic [SIZE-1:0] i_x1 = '0, i_y1 = '0, i_x2 = '0, i_y2 = '0, i_a = '0;
   logic            o_busy, o_done, o_err;
   logic [SIZE-1:0] o_x3, o_y3;
   logic [1:0]      gf_op;
   logic [SIZE-1:0] gf_in_0, gf_in_1;
   logic            gf_start;
   logic            gf_done = 1'b0;
   logic [SIZE-1:0] gf_result = '0;

   ecc_point_ctrl #(.SIZE(SIZE), .TIMEOUT_CYCLES(16)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (i_start),
      .i_mode    (i_mode),
      .i_x1      (i_x1),
      .i_y1      (i_y1),
      .i_x2      (i_x2),
      .i_y2      (i_y2),
      .i_a       (i_a),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_err     (o_err),
      .o_x3      (o_x3),
      .o_y3      (o_y3),
      .gf_op     (gf_op),
      .gf_in_0   (gf_in_0),
      .gf_in_1   (gf_in_1),
      .gf_start  (gf_start),
      .gf_done   (gf_done),
      .gf_result (gf_result)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic            err;
      logic [SIZE-1:0] x;
      logic [SIZE-1:0] y;
      int              starts;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   start_cnt = 0;
   int   done_mode = 0;   // 0 random latency, 1 stuck low, 2 tied high

   task automatic chk(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic logic [SIZE-1:0] gf_calc(input logic [1:0] op, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
      longint ra = longint'(a) % P;
      longint rb = longint'(b) % P;
      longint inv = 0;
      case (op)
         2'd0: return SIZE'((ra + rb) % P);
         2'd1: return SIZE'((ra + P - rb) % P);
         2'd2: return SIZE'((ra * rb) % P);
         default: begin
            for (int k = 1; k < P; k++) if ((rb * k) % P == 1) inv = k;
            return SIZE'((ra * inv) % P);
         end
      endcase
   endfunction

   // Behavioural GF unit: captures operands in the ISSUE cycle.
   initial begin
      logic [SIZE-1:0] res;
      int lat;
      forever begin
         @(negedge i_clk);
         if (gf_start) begin
            res = gf_calc(gf_op, gf_in_0, gf_in_1);
            lat = $urandom_range(0, MAX_LAT);
            @(posedge i_clk);
            if (done_mode == 2) begin
               #1 gf_result = res;
            end else if (done_mode == 0) begin
               repeat (lat) @(posedge i_clk);
               #1 gf_result = res;
               gf_done = 1'b1;
               @(posedge i_clk);
               #1 gf_done = 1'b0;
            end
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            start_cnt = 0;
         end else begin
            if (gf_start) start_cnt++;
            if (o_done) begin
               done_cnt++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", {31'd0, o_done}, '0);
               end else begin
                  e = exp_q.pop_front();
                  chk("o_err", {31'd0, o_err}, {31'd0, e.err});
                  chk("o_x3", o_x3, e.x);
                  chk("o_y3", o_y3, e.y);
                  chk("gf_start_pulses", SIZE'(start_cnt), SIZE'(e.starts));
               end
               start_cnt = 0;
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},  {31'd0, o_busy},   '0);
      chk({tag, "_done"},  {31'd0, o_done},   '0);
      chk({tag, "_err"},   {31'd0, o_err},    '0);
      chk({tag, "_x3"},    o_x3,              '0);
      chk({tag, "_y3"},    o_y3,              '0);
      chk({tag, "_start"}, {31'd0, gf_start}, '0);
      chk({tag, "_op"},    {30'd0, gf_op},    '0);
      chk({tag, "_in0"},   gf_in_0,           '0);
      chk({tag, "_in1"},   gf_in_1,           '0);
   endtask

   task automatic drive_req(input logic mode, input int x1, input int y1, input int x2, input int y2);
      @(negedge i_clk);
      i_mode = mode;
      i_x1 = SIZE'(x1); i_y1 = SIZE'(y1);
      i_x2 = SIZE'(x2); i_y2 = SIZE'(y2);
      i_a  = SIZE'(1);
      i_start = 1'b1;
   endtask

   task automatic run(input logic mode, input int x1, input int y1, input int x2, input int y2,
                      input logic eerr, input int ex, input int ey, input int estarts, input bit hold);
      exp_t e;
      int   d0;
      int   n;
      e.err = eerr; e.x = SIZE'(ex); e.y = SIZE'(ey); e.starts = estarts;
      exp_q.push_back(e);
      d0 = done_cnt;
      drive_req(mode, x1, y1, x2, y2);
      @(negedge i_clk);
      if (!hold) i_start = 1'b0;
      chk("busy_after_accept", {31'd0, o_busy}, 32'd1);
      // Scrambled inputs must not matter once accepted
      i_x1 = '1; i_y1 = '1; i_x2 = '1; i_y2 = '1; i_a = '1;
      n = 0;
      while (done_cnt == d0 && n < 3000) begin
         @(negedge i_clk);
         n++;
      end
      i_start = 1'b0;
      chk("done_seen", SIZE'(done_cnt), SIZE'(d0 + 1));
      repeat (10) @(negedge i_clk);
      chk("single_done", SIZE'(done_cnt), SIZE'(d0 + 1));
      chk("idle_after_done", {31'd0, o_busy}, '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k;
      repeat (3) @(negedge i_clk);
      check_all_zero("reset");
      i_rst_n = 1'b1;
      repeat (2) @(negedge i_clk);

      run(1'b0, 3, 10, 9, 7,  1'b0, 17, 20, 9, 1'b0);
      run(1'b1, 3, 10, 0, 0,  1'b0, 7, 12, 12, 1'b0);
      run(1'b0, 3, 10, 3, 13, 1'b1, 7, 12, 2, 1'b0);   // P = -Q
      run(1'b0, 3, 10, 3, 10, 1'b1, 7, 12, 2, 1'b0);   // P = Q via add
      run(1'b0, 3, 10, 9, 7,  1'b0, 17, 20, 9, 1'b1);  // i_start held

      done_mode = 2;
      gf_done = 1'b1;
      run(1'b1, 3, 10, 0, 0,  1'b0, 7, 12, 12, 1'b0);
      gf_done = 1'b0;
      done_mode = 0;

      // Reset in the WAIT of the fourth op, no completion expected
      drive_req(1'b0, 3, 10, 9, 7);
      @(negedge i_clk);
      i_start = 1'b0;
      n = 0; k = 0;
      while (n < 4 && k < 3000) begin
         if (gf_start) n++;
         if (n < 4) @(negedge i_clk);
         k++;
      end
      chk("reached_op4", SIZE'(n), SIZE'(4));
      @(posedge i_clk);
      #2 i_rst_n = 1'b0;
      #1 check_all_zero("midrst");
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (60) @(negedge i_clk);
      chk("no_done_after_abort", {31'd0, o_done}, '0);
      run(1'b0, 3, 10, 9, 7,  1'b0, 17, 20, 9, 1'b0);

`ifdef ECC_POINT_CTRL_TIMEOUT_EN
      begin
         exp_t e;
         done_mode = 1;
         e.err = 1'b1; e.x = SIZE'(17); e.y = SIZE'(20); e.starts = 1;
         exp_q.push_back(e);
         drive_req(1'b0, 3, 10, 9, 7);
         @(negedge i_clk);
         i_start = 1'b0;
         k = 0;
         while (!gf_start && k < 100) begin
            @(negedge i_clk);
            k++;
         end
         // Count from the ISSUE cycle: first WAIT is +1, DONE 16 cycles later
         k = 0;
         while (!o_done && k < 100) begin
            @(negedge i_clk);
            k++;
         end
         chk("timeout_latency", SIZE'(k), SIZE'(17));
         repeat (5) @(negedge i_clk);
         done_mode = 0;
      end
`endif

      repeat (5) @(negedge i_clk);
      chk("scoreboard_drained", SIZE'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ecc_point_ctrl.md
Name: ecc_point_ctrl

Overview:
Sequencer that computes affine elliptic-curve point addition (P+Q) or point doubling (2P) over GF(p), for curves y^2 = x^3 + a*x + b.
It drives one shared GF arithmetic unit through its op-select / start / done / result handshake and holds operands and temporaries in an internal 8-entry register file.
It sits between the scalar-multiplication control and the GF arithmetic unit.
Prime p is wired straight to the arithmetic unit and does not pass through this block.

Parameters:
SIZE, 32, field element width
TIMEOUT_CYCLES, 1024, maximum WAIT cycles per operation (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  request; accepted only when o_busy=0
i_mode  in  1  0 = add P+Q, 1 = double P
i_x1, i_y1, i_x2, i_y2  in  SIZE  operand points (x2, y2 ignored when i_mode=1)
i_a  in  SIZE  curve coefficient a
o_busy  out  1  high from the cycle after acceptance until the cycle o_done is high
o_done  out  1  one-cycle completion pulse
o_err  out  1  valid with o_done; 1 = aborted
o_x3, o_y3  out  SIZE  result point; held until the next successful completion
gf_op  out  2  0 ADD, 1 SUB, 2 MUL, 3 DIV (DIV computes in_0/in_1)
gf_in_0, gf_in_1  out  SIZE  registered operands
gf_start  out  1  one-cycle issue pulse (drives the unit's done_from_control)
gf_done  in  1  result valid for the issued op
gf_result  in  SIZE  unit result

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state = IDLE, pc = 0, register file all 0.
  - All outputs 0.
  - Reset mid-operation abandons the operation; no o_done is produced.
- Register map: r0=x1, r1=y1, r2=x2, r3=y2, r4=a, r5..r7 are temporaries.
- States and transitions:
  - IDLE: on i_start, load r0..r4 from the inputs, set pc=0, go to ISSUE.
  - ISSUE: read the ROM entry for (mode, pc). Register gf_op, gf_in_0 = r[srcA], gf_in_1 = r[srcB]. Pulse gf_start=1 for this single cycle. Go to WAIT.
    - If op=DIV and r[srcB]=0: do not pulse gf_start; go to DONE with err=1.
  - WAIT: gf_start=0. gf_op, gf_in_0 and gf_in_1 stay stable. gf_done is ignored during ISSUE and sampled only in WAIT, so a level-high or combinational done from the previous op cannot be mistaken for the new one. On the first WAIT cycle with gf_done=1: write r[dst] = gf_result, then:
    - if the entry is last, go to DONE with err=0;
    - otherwise pc++ and go to ISSUE.
  - DONE: o_done=1 for one cycle. If err=0, o_x3 = r6 and o_y3 = r7; if err=1, the previous o_x3/o_y3 are retained. Go to IDLE.
- Latency: 2 cycles plus the unit latency per op, plus 1 entry cycle and 1 DONE cycle.
- i_start while busy: ignored. Inputs are sampled only at acceptance.
- Add microprogram (9 ops):
  - r5=r3-r1; r6=r2-r0; r5=r5/r6
  - r6=r5*r5; r6=r6-r0; r6=r6-r2
  - r7=r0-r6; r7=r5*r7; r7=r7-r1
- Double microprogram (12 ops):
  - r5=r0*r0; r6=r5+r5; r5=r6+r5; r5=r5+r4
  - r6=r1+r1; r5=r5/r6
  - r6=r5*r5; r6=r6-r0; r6=r6-r0
  - r7=r0-r6; r7=r5*r7; r7=r7-r1
- Zero divisor: P=-Q (x1=x2) or doubling with y1=0 both leave a zero divisor, which is detected at the DIV ISSUE. The point-at-infinity result is reported as err=1.
- x1=x2 with y1=y2 in add mode is a caller error; it also produces err=1 (no silent fall-through to doubling).

Optional Feature:
- Macro: ECC_POINT_CTRL_TIMEOUT_EN.
- With the macro: a counter runs in WAIT. If TIMEOUT_CYCLES pass without gf_done, go to DONE with err=1. The counter clears on each ISSUE.
- Without the macro: WAIT lasts indefinitely and no counter logic is generated.

Decomposition:
- Shared package ecc_pkg:
  - opcode constants GF_ADD/SUB/MUL/DIV matching the unit's operation_select;
  - state encoding;
  - register index constants;
  - ADD_LEN=9, DBL_LEN=12;
  - ROM entry field widths.
- Sub-module ecc_ucode_rom: combinational, (mode, pc) -> {op, dst, srcA, srcB, last}.

Test Plan:
(All scenarios use p=23, a=1, and a behavioural GF unit model with random latency of 0-40 cycles, reused across scenarios.)
- Add (3,10)+(9,7): o_done with o_err=0, o_x3=17, o_y3=20, exactly 9 gf_start pulses.
- Double (3,10) with i_mode=1: o_x3=7, o_y3=12, exactly 12 gf_start pulses, no o_err.
- Add (3,10)+(3,13): o_err=1. No DIV is issued (2 gf_start pulses total). o_x3/o_y3 retain the previous result (7,12).
- Hold i_start high throughout a run: exactly one o_done and a correct result. With the model's gf_done tied high: no result is accepted in ISSUE cycles and the sequence still completes correctly.
- Drop i_rst_n during WAIT of op 4: all outputs become 0 asynchronously and o_busy=0. A following add of (3,10)+(9,7) gives (17,20).
- Macro defined, TIMEOUT_CYCLES=16, gf_done stuck at 0: o_done with o_err=1 exactly 16 cycles after the first WAIT cycle.
